// File: rtl/reset_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reset_pkg
// Description : Shared reset-cause codes, sequencer state encoding and a
//               counter-width helper for the reset sequencer slice.
// Revision    : 1.0 - initial release
// ============================================================================
package reset_pkg;

    localparam logic [1:0] RST_CAUSE_POR = 2'b00;
    localparam logic [1:0] RST_CAUSE_BTN = 2'b01;
    localparam logic [1:0] RST_CAUSE_SW  = 2'b10;

    typedef enum logic [1:0] {
        RSEQ_HOLD = 2'b00,
        RSEQ_GAP  = 2'b01,
        RSEQ_RUN  = 2'b10
    } rseq_state_e;

    // One extra bit above the largest terminal count keeps the compare simple.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage : reset_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Synchronizes a bouncing active-low pushbutton and accepts a
//               new level only after it holds for DEBOUNCE_CYCLES edges.
//               Emits a one-cycle press pulse on an accepted 1->0 change.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic internal_rst_n,
    input  logic btn_rst_ni,
    output logic btn_stable_o,
    output logic btn_press_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, 1, 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   synced;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], btn_rst_ni};
    assign synced = sync_q[SYNC_STAGES-1];

    // Synchronizer chain; idles released so POR does not look like a press.
    always_ff @(posedge clk_i or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Count consecutive mismatches; accept the new level on the last one.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (synced != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = synced;
                cnt_d    = '0;
                press_d  = ~synced;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk_i or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

    assign btn_stable_o = stable_q;
    assign btn_press_o  = press_q;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Combines POR, debounced pushbutton and software reset
//               requests; releases peripheral reset, then core reset after a
//               gap, and records the cause of the most recent reset.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEBOUNCE_CYCLES  = 16,
    parameter int HOLD_CYCLES      = 8,
    parameter int STAGE_GAP_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       internal_rst_n,
    input  logic       btn_rst_ni,
    input  logic       sw_rst_req_i,
    output logic       rst_periph_no,
    output logic       rst_core_no,
    output logic [1:0] rst_cause_o,
    output logic       busy_o
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP_CYCLES, DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP_CYCLES - 1);

    logic             btn_stable;
    logic             btn_press;

    rseq_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             periph_q, periph_d;
    logic             core_q, core_d;
    logic             busy_q, busy_d;
    logic [1:0]       cause_q, cause_d;

    btn_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i          (clk_i),
        .internal_rst_n (internal_rst_n),
        .btn_rst_ni     (btn_rst_ni),
        .btn_stable_o   (btn_stable),
        .btn_press_o    (btn_press)
    );

    // Next state, counter and registered-output values; a press always wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        periph_d = periph_q;
        core_d   = core_q;
        busy_d   = busy_q;
        cause_d  = cause_q;
        unique case (state_q)
            RSEQ_HOLD: begin
                periph_d = 1'b0;
                core_d   = 1'b0;
                busy_d   = 1'b1;
                if (btn_press) begin
                    cnt_d   = '0;
                    cause_d = RST_CAUSE_BTN;
                end else if (btn_stable) begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d  = RSEQ_GAP;
                        periph_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            RSEQ_GAP: begin
                if (btn_press) begin
                    state_d  = RSEQ_HOLD;
                    periph_d = 1'b0;
                    cnt_d    = '0;
                    cause_d  = RST_CAUSE_BTN;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = RSEQ_RUN;
                    core_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RSEQ_RUN: begin
                if (btn_press || sw_rst_req_i) begin
                    state_d  = RSEQ_HOLD;
                    periph_d = 1'b0;
                    core_d   = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    cause_d  = btn_press ? RST_CAUSE_BTN : RST_CAUSE_SW;
                end
            end
            default: begin
                state_d  = RSEQ_HOLD;
                periph_d = 1'b0;
                core_d   = 1'b0;
                busy_d   = 1'b1;
                cnt_d    = '0;
            end
        endcase
    end

    // State, counter and output flops; POR forces every reset asserted.
    always_ff @(posedge clk_i or negedge internal_rst_n) begin
        if (!internal_rst_n) begin
            state_q  <= RSEQ_HOLD;
            cnt_q    <= '0;
            periph_q <= 1'b0;
            core_q   <= 1'b0;
            busy_q   <= 1'b1;
            cause_q  <= RST_CAUSE_POR;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            periph_q <= periph_d;
            core_q   <= core_d;
            busy_q   <= busy_d;
            cause_q  <= cause_d;
        end
    end

    assign rst_periph_no = periph_q;
    assign rst_core_no   = core_q;
    assign busy_o        = busy_q;
    assign rst_cause_o   = cause_q;

endmodule : reset_sequencer
`default_nettype wire
